// File: rtl/fa_serial_ctrl_if.sv
// Request/response bundle between a datapath and the bit-serial adder.
// The requester drives start and the operands; the adder returns
// status and the registered result.
interface fa_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;

  modport master (
    output start, a, b, ci,
    input  busy, done, s, co
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, s, co
  );
endinterface

// File: rtl/fa_serial_ctrl.sv
// Bit-serial WIDTH-bit adder controller. A single one-bit full-adder cell
// (fa_case) is stepped once per clock, LSB first, for WIDTH cycles.
// Result {co,s} = a + b + ci, presented with a one-cycle done pulse.
module fa_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  fa_serial_ctrl_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One-bit full-adder cell as a truth table; returns {carry, sum}.
  function automatic logic [1:0] fa_case(input logic x, input logic y, input logic z);
    logic [1:0] r;
    case ({x, y, z})
      3'b000:  r = 2'b00;
      3'b001:  r = 2'b01;
      3'b010:  r = 2'b01;
      3'b011:  r = 2'b10;
      3'b100:  r = 2'b01;
      3'b101:  r = 2'b10;
      3'b110:  r = 2'b10;
      3'b111:  r = 2'b11;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ss_q, ss_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_sum_s;
  logic             fa_co_s;
  logic [WIDTH-1:0] ss_shift_s;

  // The single shared full-adder cell, fed from the operand LSBs and carry flop.
  always_comb begin
    {fa_co_s, fa_sum_s} = fa_case(sa_q[0], sb_q[0], c_q);
  end

  // Sum register shifted right with the fresh sum bit entering at the top;
  // written bitwise so WIDTH=1 needs no empty slice.
  always_comb begin
    ss_shift_s            = ss_q >> 1;
    ss_shift_s[WIDTH-1]   = fa_sum_s;
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ss_d    = ss_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new request too, giving back-to-back throughput.
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          c_d     = bus.ci;
          cnt_d   = {CW{1'b0}};
          ss_d    = {WIDTH{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        ss_d  = ss_shift_s;
        c_d   = fa_co_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Final bit: publish the completed sum and carry on this edge.
          s_d     = ss_shift_s;
          co_d    = fa_co_s;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags follow the next state so they come straight out of flops.
  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= {WIDTH{1'b0}};
      sb_q    <= {WIDTH{1'b0}};
      ss_q    <= {WIDTH{1'b0}};
      c_q     <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      s_q     <= {WIDTH{1'b0}};
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ss_q    <= ss_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.co   = co_q;

endmodule
